edge_line_packer: RTL and testbench
===================================

# edge_line_packer

Packs a narrow stream of DATA_W-bit update values into 512-bit memory lines, the write-side counterpart of the 64-lane banked buffer that unpacks wide lines into narrow reads. Consecutive input words fill byte lanes 0..LANES-1 in order; each completed line, or a partial line closed by `in_last`, is emitted on a valid/ready wide port with a line address and lane mask. It sits between the update-generation pipeline and the DRAM write channel. A fill register plus one output slot let input continue while the output stalls.

## Interface
- `DATA_W`, 8, width of one input word; must divide 512 (8/16/32/64)
- `ADDR_W`, 10, line address width
- `LANES` (derived), 512/DATA_W, words per line
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_data`  in  DATA_W  input word
- `in_valid`  in  1  input word present
- `in_last`  in  1  with `in_valid`, this word closes the current line and stream
- `in_ready`  out  1  input accepted when `in_valid && in_ready`
- `out_data`  out  512  line; lane i = bits [i*DATA_W +: DATA_W]
- `out_mask`  out  LANES  lane i written
- `out_addr`  out  ADDR_W  line index
- `out_last`  out  1  final line of stream
- `out_valid`  out  1  line present
- `out_ready`  in  1  line consumed when `out_valid && out_ready`

## Operation
- Fill register: `lane_cnt` (0..LANES-1), data, mask, `fill_full` flag. Output slot: data, mask, addr, last, `out_valid`.
- `slot_free` = `!out_valid || out_ready`.
- `in_ready` = `!fill_full`; it is a register output, independent of `in_valid`.
- Accepted word is written to lane `lane_cnt`, and the mask bit is set.
- The line is complete when the word lands in lane LANES-1 or `in_last`=1.
  - Not complete: `lane_cnt`++.
  - Complete and `slot_free`: the line moves to the slot at the same edge. The fill is cleared: data 0, mask 0, `lane_cnt` 0.
  - Complete and not `slot_free`: the line stays in the fill and `fill_full`=1.
- When `fill_full` and `slot_free`, the fill moves to the slot and `fill_full` clears.
- Two states: FILL (`fill_full`=0) and HOLD (`fill_full`=1). HOLD→FILL requires `slot_free`. FILL→HOLD requires a complete line with the slot not free.
- Line counter `line_idx` goes into `out_addr` on every move to the slot, then increments modulo 2^ADDR_W. A move with last=1 resets `line_idx` to 0 for the next stream.
- Unwritten lanes of a partial line are 0 in `out_data` and 0 in `out_mask`.
- `in_last` on word 0 emits a one-lane line, mask = 1.
- Output data, mask, addr and last are stable while `out_valid && !out_ready`.
- Reset mid-operation discards the partial fill and the pending slot without emitting them.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_mask` 0, `out_addr` 0, `out_last` 0, `in_ready` 1, `lane_cnt` 0, `line_idx` 0.
- Latency: the completing word is accepted at edge t; `out_valid`=1 from edge t onward. This holds when the slot is free at t.
- Throughput: one word per cycle sustained while `out_ready` stays high. There are no bubbles between lines.
- HOLD exit: the slot drains at edge t and the fill moves at edge t. `in_ready` returns to 1 after edge t, one bubble.
- Simultaneous events are resolved in the same edge:
  - a slot drain together with a new completing line loads the new line;
  - a drain together with a HOLD transfer loads the held line.
- `line_idx` wraps from 2^ADDR_W-1 to 0 silently.

## Structure
- Shared package `edge_pkg`: `LINE_W`=512, `lanes_f(DATA_W)`, the `line_t` struct (data, mask, addr, last), and `clog2` of LANES for `lane_cnt`.
- Sub-module `line_out_slot`: a one-entry valid/ready register for `line_t`. It provides load, `slot_free`, and hold-when-stalled behaviour.
- The top level holds the fill register, lane counter, line counter and HOLD flag.

## Test plan
- Stream bytes 0x00..0x7F (DATA_W=8) with `out_ready`=1:
  - two lines: addr 0 then 1;
  - line 0 lane i = i, line 1 lane i = 0x40+i;
  - mask all ones, `out_last`=0;
  - `in_ready` stays 1.
- 3 bytes 0xA1,0xA2,0xA3, the last with `in_last`:
  - one line, addr 0;
  - mask 0x7, lanes 0..2 = A1..A3, other lanes 0;
  - `out_last`=1;
  - the next stream restarts at addr 0.
- Hold `out_ready`=0 while 128 bytes are offered:
  - line 0 in the slot, line 1 in the fill;
  - `in_ready`=0 after byte 127, data stable;
  - release: line 0 drains, line 1 follows the next cycle, `in_ready`=1.
- Assert `rst` after 20 bytes of a line:
  - no output line emitted;
  - all outputs at reset values;
  - the next 64 bytes produce addr 0, full mask.
- ADDR_W=2, 5 full lines: addresses 0,1,2,3,0.
- DATA_W=32, 16 words 0x1000+i: one line, lane i = 0x1000+i, mask 0xFFFF.

Source files
------------

// File: rtl/edge_pkg.sv
// Shared definitions for the edge line packer: line geometry, lane math and
// the default line record carried by the output slot.
package edge_pkg;

  localparam int LINE_W     = 512;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 10;

  function automatic int lanes_f(input int data_w);
    return LINE_W / data_w;
  endfunction

  function automatic int lane_cnt_w_f(input int data_w);
    return $clog2(lanes_f(data_w));
  endfunction

  // Default-configuration layout; the top builds its own with its parameters.
  typedef struct packed {
    logic [LINE_W-1:0]              data;
    logic [LINE_W/DEF_DATA_W-1:0]   mask;
    logic [DEF_ADDR_W-1:0]          addr;
    logic                           last;
  } line_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_HOLD = 1'b1
  } fill_state_e;

endpackage

// File: rtl/edge_line_packer_slot.sv
// One-entry valid/ready output register for a packed line record.
// Contents hold while stalled; load is only issued when the slot is free.
module line_out_slot
  import edge_pkg::*;
#(
  parameter type line_type = edge_pkg::line_t
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     load,
  input  line_type load_line,
  input  logic     out_ready,
  output logic     slot_free,
  output logic     out_valid,
  output line_type out_line
);

  assign slot_free = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_line  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_line  <= load_line;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_line_packer.sv
// Packs DATA_W-bit words into 512-bit lines with lane mask, line address and
// last flag. A fill register plus one output slot absorb a stalled output.
//
//   state   | meaning
//   ST_FILL | fill accepting words (in_ready=1)
//   ST_HOLD | completed line waiting in fill for the slot (in_ready=0)
module edge_line_packer
  import edge_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int ADDR_W = 10,
  localparam int LANES  = lanes_f(DATA_W),
  localparam int LCW    = lane_cnt_w_f(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [LINE_W-1:0] out_data,
  output logic [LANES-1:0]  out_mask,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef struct packed {
    logic [LINE_W-1:0] data;
    logic [LANES-1:0]  mask;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } line_w_t;

  fill_state_e       state, state_nx;
  logic [LCW-1:0]    lane_cnt, lane_cnt_nx;
  logic [LINE_W-1:0] fill_data, fill_data_nx, merged_data;
  logic [LANES-1:0]  fill_mask, fill_mask_nx, merged_mask;
  logic              fill_last, fill_last_nx;
  logic [ADDR_W-1:0] line_idx, line_idx_nx;
  logic              accept, complete, load, slot_free;
  line_w_t           load_line, out_line;

  assign in_ready = (state == ST_FILL);

  always_comb begin
    merged_data = fill_data;
    merged_data[lane_cnt*DATA_W +: DATA_W] = in_data;
    merged_mask = fill_mask;
    merged_mask[lane_cnt] = 1'b1;
    accept   = in_valid && (state == ST_FILL);
    complete = accept && ((lane_cnt == LCW'(LANES-1)) || in_last);
  end

  always_comb begin
    state_nx     = state;
    lane_cnt_nx  = lane_cnt;
    fill_data_nx = fill_data;
    fill_mask_nx = fill_mask;
    fill_last_nx = fill_last;
    line_idx_nx  = line_idx;
    load         = 1'b0;
    load_line    = '0;
    case (state)
      ST_FILL: begin
        if (accept && !complete) begin
          fill_data_nx = merged_data;
          fill_mask_nx = merged_mask;
          lane_cnt_nx  = lane_cnt + LCW'(1);
        end else if (complete && slot_free) begin
          load           = 1'b1;
          load_line.data = merged_data;
          load_line.mask = merged_mask;
          load_line.addr = line_idx;
          load_line.last = in_last;
        end else if (complete) begin
          fill_data_nx = merged_data;
          fill_mask_nx = merged_mask;
          fill_last_nx = in_last;
          state_nx     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (slot_free) begin
          load           = 1'b1;
          load_line.data = fill_data;
          load_line.mask = fill_mask;
          load_line.addr = line_idx;
          load_line.last = fill_last;
          state_nx       = ST_FILL;
        end
      end
      default: state_nx = ST_FILL;
    endcase
    // Every move to the slot empties the fill and advances the line counter.
    if (load) begin
      lane_cnt_nx  = '0;
      fill_data_nx = '0;
      fill_mask_nx = '0;
      fill_last_nx = 1'b0;
      line_idx_nx  = load_line.last ? '0 : line_idx + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      lane_cnt  <= '0;
      fill_data <= '0;
      fill_mask <= '0;
      fill_last <= 1'b0;
      line_idx  <= '0;
    end else begin
      state     <= state_nx;
      lane_cnt  <= lane_cnt_nx;
      fill_data <= fill_data_nx;
      fill_mask <= fill_mask_nx;
      fill_last <= fill_last_nx;
      line_idx  <= line_idx_nx;
    end
  end

  line_out_slot #(.line_type(line_w_t)) u_slot (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_line (load_line),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_line  (out_line)
  );

  assign out_data = out_line.data;
  assign out_mask = out_line.mask;
  assign out_addr = out_line.addr;
  assign out_last = out_line.last;

endmodule

// File: tb/tb_edge_line_packer.sv
// Self-checking bench: a line-queue reference model drives per-cycle checks of
// two byte-wide packers (ADDR_W 10 and 2) and a directed 32-bit-word packer.
module tb_edge_line_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   in_data;
  logic         in_valid, in_last, out_ready;
  logic         in_ready, out_valid, out_last;
  logic [511:0] out_data;
  logic [63:0]  out_mask;
  logic [9:0]   out_addr;
  logic         in_ready2, out_valid2, out_last2;
  logic [511:0] out_data2;
  logic [63:0]  out_mask2;
  logic [1:0]   out_addr2;
  logic [31:0]  d3_data;
  logic         d3_valid, d3_last, d3_ready_o, d3_out_valid, d3_out_last, d3_out_ready;
  logic [511:0] d3_out_data;
  logic [15:0]  d3_out_mask;
  logic [9:0]   d3_out_addr;

  always #5 clk = ~clk;

  edge_line_packer #(.DATA_W(8), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_mask(out_mask), .out_addr(out_addr),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready));

  edge_line_packer #(.DATA_W(8), .ADDR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .out_data(out_data2), .out_mask(out_mask2), .out_addr(out_addr2),
    .out_last(out_last2), .out_valid(out_valid2), .out_ready(out_ready));

  edge_line_packer #(.DATA_W(32), .ADDR_W(10)) dut3 (
    .clk(clk), .rst(rst), .in_data(d3_data), .in_valid(d3_valid), .in_last(d3_last),
    .in_ready(d3_ready_o), .out_data(d3_out_data), .out_mask(d3_out_mask), .out_addr(d3_out_addr),
    .out_last(d3_out_last), .out_valid(d3_out_valid), .out_ready(d3_out_ready));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of completed lines not yet consumed (front = slot).
  typedef struct {
    logic [511:0] data;
    logic [63:0]  mask;
    int           addr;
    bit           last;
  } exp_t;

  exp_t         q[$];
  logic [511:0] cur_data;
  logic [63:0]  cur_mask;
  int           cur_n, nxt_addr;
  bit           zero_chk;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      cur_data = '0; cur_mask = '0; cur_n = 0; nxt_addr = 0;
      zero_chk = 1'b1;
    end else begin
      bit acc, drn;
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("out_valid2", out_valid2, q.size() > 0);
      check("in_ready2", in_ready2, q.size() < 2);
      if (q.size() > 0) begin
        check("out_data", out_data, q[0].data);
        check("out_mask", out_mask, q[0].mask);
        check("out_addr", out_addr, q[0].addr % 1024);
        check("out_last", out_last, q[0].last);
        check("out_addr2", out_addr2, q[0].addr % 4);
        check("out_data2", out_data2, q[0].data);
      end
      if (zero_chk) begin
        check("rst_data", out_data, 0);
        check("rst_mask", out_mask, 0);
        check("rst_addr", out_addr, 0);
        check("rst_last", out_last, 0);
        zero_chk = 1'b0;
      end
      acc = in_valid && (q.size() < 2);
      drn = out_ready && (q.size() > 0);
      if (drn) void'(q.pop_front());
      if (acc) begin
        cur_data[cur_n*8 +: 8] = in_data;
        cur_mask[cur_n] = 1'b1;
        cur_n++;
        if (cur_n == 64 || in_last) begin
          q.push_back('{data: cur_data, mask: cur_mask, addr: nxt_addr, last: in_last});
          nxt_addr = in_last ? 0 : nxt_addr + 1;
          cur_data = '0; cur_mask = '0; cur_n = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    bit ok = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    if (!ok) check("send_timeout", 0, 1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
  endtask

  initial begin
    logic [511:0] exp3;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    d3_data = '0; d3_valid = 1'b0; d3_last = 1'b0; d3_out_ready = 1'b1;
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_in_ready3", d3_ready_o, 1);

    // 32-bit words: sixteen words fill one line
    exp3 = '0;
    for (int i = 0; i < 16; i++) begin
      d3_valid = 1'b1; d3_data = 32'h1000 + i;
      exp3[i*32 +: 32] = 32'h1000 + i;
      tick();
    end
    d3_valid = 1'b0;
    check("w32_valid", d3_out_valid, 1);
    check("w32_data", d3_out_data, exp3);
    check("w32_mask", d3_out_mask, 16'hFFFF);
    check("w32_addr", d3_out_addr, 0);
    check("w32_last", d3_out_last, 0);
    tick();
    check("w32_drained", d3_out_valid, 0);

    // two full lines with free output
    for (int i = 0; i < 128; i++) send(8'(i), 1'b0);
    tick(); tick();

    // short stream closed by last, then a fresh stream
    do_reset();
    send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b1);
    tick();
    send(8'h55, 1'b1);
    tick();

    // output stalled across two lines, then released
    out_ready = 1'b0;
    for (int i = 0; i < 128; i++) send(8'(i + 3), 1'b0);
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (4) tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    // reset mid-line, then five full lines (ADDR_W=2 wraps)
    for (int i = 0; i < 20; i++) send(8'(i), 1'b0);
    do_reset();
    for (int i = 0; i < 320; i++) send(8'(i * 7), 1'b0);
    tick(); tick();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
